// File: rtl/dma_rdata_realigner_if.sv
// Handshake bundle between the DMA reader control/R channel and the realigner:
// cfg handshake, input beat stream and realigned output beat stream.
interface dma_rdata_realigner_if #(
    parameter int DATA_WIDTH = 128,
    parameter int WOFFS_BITS = 4
);
    logic                  i_cfg_valid;
    logic                  o_cfg_ready;
    logic [WOFFS_BITS-1:0] i_cfg_offs;
    logic [7:0]            i_cfg_len;

    logic                  i_s_valid;
    logic                  o_s_ready;
    logic [DATA_WIDTH-1:0] i_s_data;
    logic                  i_s_last;

    logic                  o_m_valid;
    logic                  i_m_ready;
    logic [DATA_WIDTH-1:0] o_m_data;
    logic                  o_m_last;

    modport slave (
        input  i_cfg_valid, i_cfg_offs, i_cfg_len,
        input  i_s_valid, i_s_data, i_s_last,
        input  i_m_ready,
        output o_cfg_ready, o_s_ready,
        output o_m_valid, o_m_data, o_m_last
    );

    modport master (
        output i_cfg_valid, i_cfg_offs, i_cfg_len,
        output i_s_valid, i_s_data, i_s_last,
        output i_m_ready,
        input  o_cfg_ready, o_s_ready,
        input  o_m_valid, o_m_data, o_m_last
    );
endinterface

// File: rtl/dma_rdata_realigner.sv
// Element-granular read-data realigner: shifts a beat stream starting at element k so output beats are word-aligned.
// Optional sticky last-flag protocol check is enabled with `define DMA_REALIGN_ERR_EN.
//
// state  | meaning
// IDLE   | waiting for a cfg handshake
// PRIME  | k!=0: first input beat goes to the hold register only
// STREAM | each input beat produces one realigned output beat
// FLUSH  | last output beat loaded, waiting for its handshake
module dma_rdata_realigner #(
    parameter int DATA_WIDTH = 128,
    parameter int ELM_BITS   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    dma_rdata_realigner_if.slave  bus,
    output logic                  o_busy,
    output logic                  o_err
);
    localparam int N_ELEMENTS = DATA_WIDTH / ELM_BITS;
    localparam int WOFFS_BITS = $clog2(N_ELEMENTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t                  r_state;
    logic [WOFFS_BITS-1:0]   r_offs;
    logic [7:0]              r_len;
    logic [8:0]              r_cnt;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic                    r_m_valid;
    logic                    r_m_last;

    logic                    w_s_ready;
    logic                    w_s_hs;
    logic                    w_m_hs;
    logic                    w_cnt_final;
    logic [2*DATA_WIDTH-1:0] w_cat;
    logic [DATA_WIDTH-1:0]   w_aligned;

    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            S_PRIME:  w_s_ready = 1'b1;
            S_STREAM: w_s_ready = !r_m_valid || bus.i_m_ready;
            default:  w_s_ready = 1'b0;
        endcase
    end

    assign w_s_hs      = bus.i_s_valid && w_s_ready;
    assign w_m_hs      = r_m_valid && bus.i_m_ready;
    assign w_cnt_final = (r_cnt == {1'b0, r_len});

    // Output element e takes hold[e+k] while it exists, otherwise in[e+k-N].
    always_comb begin
        w_cat     = {bus.i_s_data, r_hold};
        w_aligned = bus.i_s_data;
        if (r_offs != '0)
            w_aligned = w_cat[int'(r_offs) * ELM_BITS +: DATA_WIDTH];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_offs    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            if (w_m_hs)
                r_m_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_cfg_valid) begin
                        r_offs  <= bus.i_cfg_offs;
                        r_len   <= bus.i_cfg_len;
                        r_cnt   <= '0;
                        r_state <= (bus.i_cfg_offs != '0) ? S_PRIME : S_STREAM;
                    end
                end
                S_PRIME: begin
                    if (w_s_hs) begin
                        r_hold  <= bus.i_s_data;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_s_hs) begin
                        r_m_data  <= w_aligned;
                        r_m_valid <= 1'b1;
                        r_m_last  <= w_cnt_final;
                        r_cnt     <= r_cnt + 9'd1;
                        r_hold    <= bus.i_s_data;
                        if (w_cnt_final)
                            r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_m_hs)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so no handshake can complete during the reset cycle.
    assign bus.o_cfg_ready = (r_state == S_IDLE) && !i_rst;
    assign bus.o_s_ready   = w_s_ready && !i_rst;
    assign bus.o_m_valid   = r_m_valid && !i_rst;
    assign bus.o_m_data    = r_m_data;
    assign bus.o_m_last    = r_m_last;
    assign o_busy          = (r_state != S_IDLE);

`ifdef DMA_REALIGN_ERR_EN
    logic [8:0] r_in_cnt;
    logic       r_err;
    logic [8:0] w_in_final;

    assign w_in_final = {1'b0, r_len} + 9'(r_offs != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_cnt <= '0;
            r_err    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_in_cnt <= '0;
        end else if (w_s_hs) begin
            r_in_cnt <= r_in_cnt + 9'd1;
            if (bus.i_s_last != (r_in_cnt == w_in_final))
                r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_last;
    assign w_unused_last = bus.i_s_last;
    assign o_err         = 1'b0;
`endif
endmodule

// File: tb/tb_dma_rdata_realigner.sv
// Randomized self-checking bench for dma_rdata_realigner; expected beats come from a flat element-stream model.
module tb_dma_rdata_realigner;
    localparam int DW = 128;
    localparam int NE = 16;

    logic clk;
    logic rst;
    logic busy;
    logic err;
    int   cyc;

    int n_cmp;
    int n_bad;

    dma_rdata_realigner_if #(.DATA_WIDTH(DW), .WOFFS_BITS(4)) bus ();

    dma_rdata_realigner #(.DATA_WIDTH(DW), .ELM_BITS(8)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bus),
        .o_busy (busy),
        .o_err  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] in_beats[$];
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int            in_cyc[$];
    int            out_cyc[$];
    int            in_used;
    int            stall_viol;
    int            err_cyc;
    int            cfg_wait;
    bit            timeout;

    // Output beat j, element e is element (k + j*N + e) of the concatenated input stream.
    function automatic logic [DW-1:0] exp_beat(input int j, input int k);
        logic [DW-1:0] r;
        logic [DW-1:0] src;
        int g;
        r = '0;
        for (int e = 0; e < NE; e++) begin
            g   = k + j * NE + e;
            src = in_beats[g / NE];
            r[e*8 +: 8] = src[(g % NE) * 8 +: 8];
        end
        return r;
    endfunction

    task automatic run_burst(input int k, input int len, input int rmode, input bit vrand,
                             input bit rnd_data, input int bad_idx);
        int n_in;
        int in_idx;
        int budget;
        logic [DW-1:0] beat;
        logic [DW-1:0] held_d;
        logic held_l;
        bit held;
        n_in = len + 1 + ((k != 0) ? 1 : 0);
        in_beats.delete(); got_data.delete(); got_last.delete();
        in_cyc.delete(); out_cyc.delete();
        stall_viol = 0; timeout = 0; err_cyc = -1; cfg_wait = 0;
        for (int b = 0; b < n_in; b++) begin
            for (int i = 0; i < NE; i++)
                beat[i*8 +: 8] = rnd_data ? 8'($urandom) : 8'(b * NE + i);
            in_beats.push_back(beat);
        end
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_offs  = 4'(k);
        bus.i_cfg_len   = 8'(len);
        forever begin
            @(negedge clk);
            if (bus.o_cfg_ready) break;
            cfg_wait++;
            if (cfg_wait > 50) begin timeout = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.i_cfg_valid = 1'b0;
        in_idx = 0; held = 0; budget = 0;
        while (got_data.size() < len + 1 && budget < 400) begin
            bus.i_s_valid = (in_idx < n_in) && (!vrand || $urandom_range(0, 3) != 0);
            bus.i_s_data  = (in_idx < n_in) ? in_beats[in_idx] : '0;
            bus.i_s_last  = (in_idx == n_in - 1) || (in_idx == bad_idx);
            bus.i_m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held && (bus.o_m_data !== held_d || bus.o_m_last !== held_l || bus.o_m_valid !== 1'b1))
                stall_viol++;
            if (bus.o_m_valid && !bus.i_m_ready && bus.i_s_valid && bus.o_s_ready)
                stall_viol++;
            if (err_cyc < 0 && err === 1'b1) err_cyc = cyc;
            if (bus.i_s_valid && bus.o_s_ready) begin
                in_cyc.push_back(cyc);
                in_idx++;
            end
            if (bus.o_m_valid && bus.i_m_ready) begin
                got_data.push_back(bus.o_m_data);
                got_last.push_back(bus.o_m_last);
                out_cyc.push_back(cyc);
            end
            held   = bus.o_m_valid && !bus.i_m_ready;
            held_d = bus.o_m_data;
            held_l = bus.o_m_last;
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 400) timeout = 1;
        in_used = in_idx;
        bus.i_s_valid = 1'b0;
        bus.i_s_last  = 1'b0;
        bus.i_m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_m_valid, bus.o_m_last, bus.o_s_ready, busy, err, bus.o_cfg_ready} !== 6'b000001) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 000001",
                     {bus.o_m_valid, bus.o_m_last, bus.o_s_ready, busy, err, bus.o_cfg_ready});
        end
        n_cmp++;
        if (bus.o_m_data !== '0) begin
            n_bad++; $display("FAIL reset_data got %h want 0", bus.o_m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned();
        run_burst(0, 3, 0, 0, 0, -1);
        n_cmp++;
        if (got_data.size() !== 4 || timeout) begin
            n_bad++; $display("FAIL aligned_count got %0d timeout %0d want 4", got_data.size(), timeout);
        end
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got_data[j] !== in_beats[j] || got_last[j] !== (j == 3)) begin
                n_bad++; $display("FAIL aligned_beat%0d got %h/%b want %h/%b", j, got_data[j], got_last[j], in_beats[j], j == 3);
            end
            n_cmp++;
            if (out_cyc[j] !== in_cyc[j] + 1) begin
                n_bad++; $display("FAIL aligned_latency%0d got %0d want %0d", j, out_cyc[j], in_cyc[j] + 1);
            end
        end
        n_cmp++;
        if (in_used !== 4) begin
            n_bad++; $display("FAIL aligned_inputs got %0d want 4", in_used);
        end
    endtask

    task automatic test_offset();
        logic [DW-1:0] w;
        run_burst(3, 1, 0, 0, 0, -1);
        n_cmp++;
        if (got_data.size() !== 2 || in_used !== 3) begin
            n_bad++; $display("FAIL offs3_counts got %0d/%0d want 2/3", got_data.size(), in_used);
        end
        for (int i = 0; i < NE; i++) w[i*8 +: 8] = 8'(8'h03 + i);
        n_cmp++;
        if (got_data[0] !== w || got_last[0] !== 1'b0) begin
            n_bad++; $display("FAIL offs3_beat0 got %h/%b want %h/0", got_data[0], got_last[0], w);
        end
        for (int i = 0; i < NE; i++) w[i*8 +: 8] = 8'(8'h13 + i);
        n_cmp++;
        if (got_data[1] !== w || got_last[1] !== 1'b1) begin
            n_bad++; $display("FAIL offs3_beat1 got %h/%b want %h/1", got_data[1], got_last[1], w);
        end

        run_burst(15, 0, 0, 0, 0, -1);
        w[7:0] = 8'h0F;
        for (int i = 1; i < NE; i++) w[i*8 +: 8] = 8'(8'h10 + i - 1);
        n_cmp++;
        if (got_data.size() !== 1 || got_data[0] !== w || got_last[0] !== 1'b1) begin
            n_bad++; $display("FAIL offs15_beat got %h want %h", got_data[0], w);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || bus.o_cfg_ready !== 1'b1) begin
            n_bad++; $display("FAIL offs15_idle got busy %b cfg_ready %b want 0/1", busy, bus.o_cfg_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int bad;
        run_burst(5, 7, 1, 0, 1, -1);
        bad = 0;
        for (int j = 0; j < 8; j++)
            if (got_data[j] !== exp_beat(j, 5) || got_last[j] !== (j == 7)) bad++;
        n_cmp++;
        if (bad !== 0 || got_data.size() !== 8) begin
            n_bad++; $display("FAIL stall_data got %0d wrong beats of %0d want 0 of 8", bad, got_data.size());
        end
        n_cmp++;
        if (stall_viol !== 0 || in_used !== 9) begin
            n_bad++; $display("FAIL stall_hold got viol %0d inputs %0d want 0/9", stall_viol, in_used);
        end

        run_burst(5, 7, 0, 0, 1, -1);
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            if (got_data[j] !== exp_beat(j, 5)) bad++;
            if (out_cyc[j] !== in_cyc[j + 1] + 1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL stream_latency got %0d errors want 0", bad);
        end
        n_cmp++;
        if (out_cyc[7] - out_cyc[0] !== 7) begin
            n_bad++; $display("FAIL stream_bubbles got span %0d want 7", out_cyc[7] - out_cyc[0]);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int len;
        int bad;
        for (int b = 0; b < 8; b++) begin
            k   = $urandom_range(0, 15);
            len = $urandom_range(0, 12);
            run_burst(k, len, 2, 1, 1, -1);
            bad = 0;
            for (int j = 0; j <= len; j++)
                if (got_data[j] !== exp_beat(j, k) || got_last[j] !== (j == len)) bad++;
            n_cmp++;
            if (bad !== 0 || got_data.size() !== len + 1 || timeout) begin
                n_bad++; $display("FAIL b2b_data burst %0d k=%0d len=%0d got %0d bad of %0d want 0", b, k, len, bad, got_data.size());
            end
            n_cmp++;
            if (in_used !== len + 1 + ((k != 0) ? 1 : 0) || stall_viol !== 0 || cfg_wait !== 0) begin
                n_bad++; $display("FAIL b2b_proto burst %0d got in %0d viol %0d cfgwait %0d", b, in_used, stall_viol, cfg_wait);
            end
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL b2b_err got %b want 0", err);
        end
    endtask

    task automatic test_mid_reset();
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_offs  = 4'd4;
        bus.i_cfg_len   = 8'd3;
        bus.i_m_ready   = 1'b1;
        @(posedge clk); #1;
        bus.i_cfg_valid = 1'b0;
        bus.i_s_valid   = 1'b1;
        bus.i_s_last    = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.i_s_data = {4{32'($urandom)}};
            @(posedge clk); #1;
        end
        bus.i_s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.o_m_valid !== 1'b0 || bus.o_s_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst_cycle got valid %b s_ready %b want 0/0", bus.o_m_valid, bus.o_s_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_m_valid, bus.o_m_last, busy, bus.o_cfg_ready} !== 4'b0001 || bus.o_m_data !== '0) begin
            n_bad++; $display("FAIL midrst_after got %b data %h want 0001 data 0",
                              {bus.o_m_valid, bus.o_m_last, busy, bus.o_cfg_ready}, bus.o_m_data);
        end
        @(posedge clk); #1;
        run_burst(0, 0, 0, 0, 1, -1);
        n_cmp++;
        if (got_data.size() !== 1 || got_data[0] !== in_beats[0] || got_last[0] !== 1'b1 || in_used !== 1) begin
            n_bad++; $display("FAIL midrst_next got %h want %h", got_data[0], in_beats[0]);
        end
    endtask

    task automatic test_err_flag();
        int bad;
        run_burst(2, 1, 0, 0, 0, 1);
        bad = 0;
        for (int j = 0; j < 2; j++)
            if (got_data[j] !== exp_beat(j, 2)) bad++;
        n_cmp++;
        if (bad !== 0 || got_data.size() !== 2) begin
            n_bad++; $display("FAIL err_data got %0d bad beats want 0", bad);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef DMA_REALIGN_ERR_EN
        n_cmp++;
        if (err_cyc !== in_cyc[1] + 1) begin
            n_bad++; $display("FAIL err_onset got cycle %0d want %0d", err_cyc, in_cyc[1] + 1);
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL err_sticky got %b want 1", err);
        end
`else
        n_cmp++;
        if (err !== 1'b0 || err_cyc !== -1) begin
            n_bad++; $display("FAIL err_disabled got %b want 0", err);
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.i_cfg_valid = 1'b0;
        bus.i_cfg_offs  = '0;
        bus.i_cfg_len   = '0;
        bus.i_s_valid   = 1'b0;
        bus.i_s_data    = '0;
        bus.i_s_last    = 1'b0;
        bus.i_m_ready   = 1'b1;
        test_reset();
        test_aligned();
        test_offset();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_err_flag();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
